// File: rtl/pulse_sched.sv
// pulse_sched: round-robin scheduler sharing one registered pulse line among N_REQ requesters
module pulse_sched #(
    parameter int N_REQ     = 4,
    parameter int MAX_WIDTH = 255,
    parameter int GAP       = 2,
    localparam int WW = $clog2(MAX_WIDTH + 1),
    localparam int SW = $clog2(N_REQ),
    localparam int GW = $clog2(GAP + 1)
) (
    input  logic                clk,
    input  logic                i_reset_n,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ*WW-1:0] i_width,
    output logic                o_pulse,
    output logic [SW-1:0]       o_sel,
    output logic [N_REQ-1:0]    o_ack,
    output logic                o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;
    state_t           state_q, state_d;
    logic [WW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [SW-1:0]    last_q, last_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             found;
    logic [SW-1:0]    pick, idx;
    logic [WW-1:0]    width;
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = SW'((int'(last_q) + i) % N_REQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end
    assign width = i_width[pick*WW +: WW];
    // outputs lag the state by one cycle so every port comes straight from a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        last_d  = last_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: if (found) begin
                state_d = S_PULSE;
                sel_d   = pick;
                cnt_d   = (width == '0) ? WW'(1) : width;
            end
            S_PULSE: begin
                cnt_d = cnt_q - WW'(1);
                if (cnt_q == WW'(1)) begin
                    state_d = S_GAP;
                    gap_d   = GW'(GAP);
                end
            end
            S_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q == GW'(1)) begin
                    state_d = S_IDLE;
                    last_d  = sel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pulse_d = state_q == S_PULSE;
        busy_d  = state_q != S_IDLE;
        ack_d   = (state_q == S_GAP && gap_q == GW'(GAP)) ? N_REQ'(1) << sel_q : '0;
    end
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            last_q  <= SW'(N_REQ - 1);
            sel_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end
    assign o_pulse = pulse_q;
    assign o_sel   = sel_q;
    assign o_ack   = ack_q;
    assign o_busy  = busy_q;
endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: directed stimulus with a scoreboard of expected pulses checked by a monitor
module tb_pulse_sched;
    localparam int N = 4;
    localparam int WW = 8;
    localparam int GAP = 2;
    typedef struct {
        int sel;
        int w;
        int low;
    } exp_t;
    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic [N-1:0]  i_req = '0;
    logic [N*WW-1:0] i_width = '0;
    logic          o_pulse, o_busy;
    logic [1:0]    o_sel;
    logic [N-1:0]  o_ack;
    exp_t          sb[$];
    exp_t          cur;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  ack_prev = '0, re_pend = '0, rearm = '0, hold = '0;
    bit            in_pulse = 1'b0, prev_p = 1'b0;
    int            len = 0;
    int            since_fall = -1;
    pulse_sched #(.N_REQ(N), .MAX_WIDTH(255), .GAP(GAP)) dut (
        .clk(clk),
        .i_reset_n(i_reset_n),
        .i_req(i_req),
        .i_width(i_width),
        .o_pulse(o_pulse),
        .o_sel(o_sel),
        .o_ack(o_ack),
        .o_busy(o_busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (!i_reset_n) begin
            chk("rst_pulse", int'(o_pulse), 0);
            chk("rst_ack", int'(o_ack), 0);
            chk("rst_busy", int'(o_busy), 0);
            in_pulse = 1'b0;
            prev_p = 1'b0;
            since_fall = -1;
        end else begin
            if (o_pulse && !prev_p) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: sel %0d, none expected", o_sel);
                end else begin
                    cur = sb.pop_front();
                    if (cur.low >= 0) chk("low_gap", since_fall, cur.low);
                end
                in_pulse = 1'b1;
                len = 0;
            end
            if (o_pulse) begin
                len++;
                chk("sel", int'(o_sel), cur.sel);
                chk("busy_pulse", int'(o_busy), 1);
                chk("ack_pulse", int'(o_ack), 0);
            end else if (prev_p) begin
                chk("width", len, cur.w);
                chk("ack", int'(o_ack), 1 << cur.sel);
                chk("busy_gap", int'(o_busy), 1);
                in_pulse = 1'b0;
                since_fall = 1;
            end else begin
                chk("ack_idle", int'(o_ack), 0);
                if (since_fall >= 0) begin
                    since_fall++;
                    if (since_fall <= GAP) chk("busy_gap", int'(o_busy), 1);
                    else if (since_fall == GAP + 1) chk("busy_fall", int'(o_busy), 0);
                end
            end
            prev_p = o_pulse;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        i_req    = (i_req | re_pend) & ~(ack_prev & ~hold);
        re_pend  = ack_prev & rearm;
        rearm    = rearm & ~ack_prev;
        ack_prev = o_ack;
    endtask
    task automatic push(input int sel, input int w, input int low);
        exp_t e;
        e.sel = sel;
        e.w = w;
        e.low = low;
        sb.push_back(e);
    endtask
    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, %0d pulses outstanding", name, n, sb.size());
        end
    endtask
    task automatic wait_sel(input string name, input int sel);
        int n = 0;
        while (!(o_pulse && int'(o_sel) == sel) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s: no pulse for requester %0d within %0d cycles", name, sel, n);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        i_width = {8'd4, 8'd3, 8'd2, 8'd1};
        repeat (3) tick();
        chk("rst_sel", int'(o_sel), 0);
        i_reset_n = 1'b1;
        push(0, 1, -1);
        push(1, 2, GAP + 1);
        push(2, 3, GAP + 1);
        push(3, 4, GAP + 1);
        push(0, 1, GAP + 1);
        rearm = 4'b0001;
        i_req = 4'b1111;
        wait_done("round_robin", 200);
        i_width[7:0] = 8'd3;
        push(0, 3, -1);
        i_req = 4'b0001;
        tick();
        chk("lat_sampled", int'(o_pulse), 0);
        tick();
        chk("lat_first", int'(o_pulse), 1);
        wait_done("single", 50);
        i_width[7:0] = 8'd0;
        push(0, 1, -1);
        i_req = 4'b0001;
        wait_done("clamp", 50);
        i_width[7:0] = 8'd255;
        push(0, 255, -1);
        i_req = 4'b0001;
        wait_done("max_width", 400);
        i_width[7:0] = 8'd8;
        push(0, 8, -1);
        i_req = 4'b0001;
        wait_sel("mid_start", 0);
        tick();
        i_req = '0;
        i_width[7:0] = 8'd1;
        wait_done("mid_change", 50);
        i_width[23:16] = 8'd3;
        i_width[15:8] = 8'd2;
        push(2, 3, -1);
        push(1, 2, GAP + 1);
        push(2, 3, GAP + 1);
        hold = 4'b0100;
        i_req = 4'b0100;
        wait_sel("fair_start", 2);
        i_req[1] = 1'b1;
        wait_sel("fair_one", 1);
        hold = '0;
        wait_done("fairness", 100);
        i_width[31:24] = 8'd6;
        push(3, 6, -1);
        i_req = 4'b1000;
        wait_sel("rst_start", 3);
        tick();
        tick();
        #2;
        i_reset_n = 1'b0;
        i_req = 4'b0100;
        #1;
        chk("async_pulse", int'(o_pulse), 0);
        chk("async_busy", int'(o_busy), 0);
        chk("async_ack", int'(o_ack), 0);
        chk("async_sel", int'(o_sel), 0);
        tick();
        tick();
        i_reset_n = 1'b1;
        i_width[23:16] = 8'd4;
        push(2, 4, -1);
        wait_done("post_reset", 50);
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_sched.md
# pulse_sched

Round-robin scheduler that shares one registered pulse output among N_REQ requesters. Each requester raises a level request with a programmable width. The scheduler grants one requester at a time and drives a pulse of exactly that many cycles on the shared line. It then acknowledges the requester and enforces a fixed idle gap before the next grant. It sits between the control/register logic and any downstream single-pulse consumer, where it replaces per-channel pulse stretchers.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- MAX_WIDTH, 255, largest legal pulse width in cycles; WW = $clog2(MAX_WIDTH+1)
- GAP, 2, idle cycles forced between pulses (≥1)

Ports:
- clk  input  1  clock; all logic on posedge
- i_reset_n  input  1  reset, asynchronous, active-low
- i_req  input  N_REQ  level request per requester, held until its ack
- i_width  input  N_REQ*WW  packed widths; requester k uses bits [k*WW +: WW]
- o_pulse  output  1  shared pulse, registered
- o_sel  output  $clog2(N_REQ)  index of the currently/last granted requester
- o_ack  output  N_REQ  one-hot, one-cycle completion strobe
- o_busy  output  1  high in PULSE and GAP states

## Operation
- FSM states: IDLE, PULSE, GAP. Reset state is IDLE.
- **IDLE:**
  - If any i_req bit is high, grant the first requester found searching upward from (last+1) mod N_REQ, wrapping.
  - On grant, latch its width into the down-counter, set o_sel, and go to PULSE.
  - With no request, stay in IDLE.
- **Width rule:** a latched width of 0 is clamped to 1. Changes to i_width after the grant are ignored.
- **PULSE:**
  - o_pulse is high and the counter decrements each cycle.
  - After the final pulse cycle, go to GAP, load the gap counter with GAP, and assert o_ack[o_sel] for that first GAP cycle only.
- **GAP:** after GAP cycles, return to IDLE and update the round-robin pointer last = o_sel.
- **Round-robin pointer:** resets to N_REQ-1, so requester 0 has priority at the first grant.
- **Pulses are non-abortable.** If i_req drops mid-pulse, the pulse still completes and is still acked.
- **Requester contract:** drop i_req the cycle after seeing its ack. A request still high in IDLE counts as a new request.
- **Reset:** assertion at any time forces IDLE, o_pulse=0, o_ack=0, o_busy=0, o_sel=0, pointer=N_REQ-1 and clears both counters. A pulse in progress is cut immediately and is not acked.

## Timing
- **Grant latency:** i_req sampled high at edge t in IDLE gives o_pulse high in the cycles after edges t+1 … t+W (exactly W cycles, W = clamped width).
- o_ack[k] is high for exactly one cycle, immediately following the last o_pulse cycle.
- o_busy rises with o_pulse and falls GAP cycles after o_pulse falls.
- **Earliest next grant:** the next pulse can start GAP+1 cycles after o_pulse falls, i.e. a minimum GAP low cycles between pulses plus one IDLE sampling cycle. Back-to-back period is W+GAP+1.
- All outputs are registered; there are no combinational paths from i_req or i_width to any output.
- o_sel is stable from the grant edge through the GAP state, and holds its last value in IDLE.

## Test plan
- **Single request:** i_req=4'b0001, width0=3 → o_pulse high 3 cycles starting 1 cycle after the request is sampled. o_ack=0001 for 1 cycle after. o_busy high 3+2 cycles.
- **Simultaneous requests:** i_req=4'b1111 held (dropping after ack, then re-raised), widths 1,2,3,4 → grant order 0,1,2,3,0. Pulse lengths 1,2,3,4. Each low gap = GAP (2) cycles, with next grant one IDLE cycle later.
- **Width clamp and max:** width=0 → 1-cycle pulse. width=255 → 255-cycle pulse, counter does not wrap.
- **Mid-pulse changes:** i_req dropped and i_width changed to 1 at cycle 2 of a width-8 pulse → full 8-cycle pulse and ack still issued.
- **Fairness:** requester 2 held continuously, requester 1 raised during requester 2's pulse → next grant goes to 1 only if the pointer search reaches it first. From last=2 the order is 3,0,1, so requester 1 wins over a re-request from 2.
- **Reset mid-pulse:** assert i_reset_n=0 in cycle 3 of a width-6 pulse → o_pulse, o_busy and o_ack drop asynchronously with no ack. After release with i_req=4'b0100, requester 2 is granted normally.
